issue_queue: RTL and testbench

Parametrised instruction buffer and dual-issue dispatcher between instruction fetch and the two ALU lanes of the dual-issue MIPS-subset core. Replaces the fixed 32-entry dispatcher with its ad-hoc wait flag. Features: configurable depth, a proper ready/valid backpressure handshake, flush on taken jump, and an explicit pair-hazard check. Each cycle it issues 0, 1 or 2 instructions in program order.

---
 rtl/core_pkg.sv | 54 +++++
 rtl/issue_queue_if.sv | 38 +++
 rtl/pair_hazard.sv | 30 +++
 rtl/issue_queue.sv | 172 +++++++++++++++++
 tb/tb_issue_queue.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared MIPS-subset decode helpers: opcodes, register-field extraction, destination and control-flow classification.
// Pure combinational functions; no state, no latency, no backpressure.
// Consumed by the issue queue hazard check and by scoreboards that replay the same pairing rules.
package core_pkg;

    localparam int MIPS_IW = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        FLD_RS,
        FLD_RT,
        FLD_RD
    } field_e;

    function automatic logic [4:0] get_field(input logic [31:0] inst, input field_e fld);
        logic [4:0] r;
        case (fld)
            FLD_RS:  r = inst[25:21];
            FLD_RT:  r = inst[20:16];
            default: r = inst[15:11];
        endcase
        return r;
    endfunction

    function automatic logic [4:0] dest_reg(input logic [31:0] inst);
        logic [4:0] d;
        d = REG_ZERO;
        case (inst[31:26])
            OP_RTYPE: d = (inst[5:0] == FUNCT_JR) ? REG_ZERO : get_field(inst, FLD_RD);
            OP_ADDI,
            OP_LW:    d = get_field(inst, FLD_RT);
            OP_JAL:   d = REG_RA;
            default:  d = REG_ZERO;
        endcase
        return d;
    endfunction

    function automatic logic is_control(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        return ((op == OP_RTYPE) && (inst[5:0] == FUNCT_JR)) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Fetch-side pair handshake, flush/stall controls, dual-lane issue outputs and performance counters.
// Wires only; no latency of its own.
// in_ready is the fetch backpressure signal; stall is the downstream hold.
interface issue_queue_if #(
    parameter int IW = 32,
    parameter int AW = 32,
    parameter int CW = 4
);
    logic [1:0]    in_valid;
    logic [IW-1:0] in_inst0;
    logic [IW-1:0] in_inst1;
    logic [AW-1:0] in_pc;
    logic          in_ready;
    logic          flush;
    logic          stall;
    logic [IW-1:0] out_inst0;
    logic [IW-1:0] out_inst1;
    logic [AW-1:0] out_pc0;
    logic [AW-1:0] out_pc1;
    logic          out_valid0;
    logic          out_valid1;
    logic [CW-1:0] count;
    logic [31:0]   stat_dual;
    logic [31:0]   stat_single;
    logic [31:0]   stat_bubble;

    modport master (
        output in_valid, in_inst0, in_inst1, in_pc, flush, stall,
        input  in_ready, out_inst0, out_inst1, out_pc0, out_pc1,
        input  out_valid0, out_valid1, count, stat_dual, stat_single, stat_bubble
    );

    modport slave (
        input  in_valid, in_inst0, in_inst1, in_pc, flush, stall,
        output in_ready, out_inst0, out_inst1, out_pc0, out_pc1,
        output out_valid0, out_valid1, count, stat_dual, stat_single, stat_bubble
    );
endinterface

// File: rtl/pair_hazard.sv
// Decides whether head entries H0 and H1 may issue together in one cycle.
// Purely combinational, zero latency.
// No handshake; the caller qualifies dual_ok with occupancy and stall/flush.
module pair_hazard
    import core_pkg::*;
(
    input  logic [31:0] h0,
    input  logic [31:0] h1,
    output logic        dual_ok
);

    logic [4:0] dest0;
    logic [4:0] dest1;
    logic [4:0] rs1;
    logic [4:0] rt1;
    logic       raw;
    logic       waw;

    always_comb begin
        dest0   = dest_reg(h0);
        dest1   = dest_reg(h1);
        rs1     = get_field(h1, FLD_RS);
        rt1     = get_field(h1, FLD_RT);
        // $zero is never a real producer, so it cannot create a dependency.
        raw     = (dest0 != REG_ZERO) && ((dest0 == rs1) || (dest0 == rt1));
        waw     = (dest0 != REG_ZERO) && (dest0 == dest1);
        dual_ok = !is_control(h0) && !is_control(h1) && !raw && !waw;
    end

endmodule

// File: rtl/issue_queue.sv
// Circular instruction buffer with in-order 0/1/2-wide issue to two ALU lanes; ISSUE_STATS_EN adds issue counters.
// Enqueue at edge N, earliest issue at edge N+1; outputs are registered.
// in_ready drops when fewer than two slots are free (registered count only); stall holds outputs, flush empties everything.
module issue_queue
    import core_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int IW      = 32,
    parameter int AW      = 32,
    parameter int PC_STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("issue_queue: DEPTH must be a power of two and at least 4");
    end
    if (IW < MIPS_IW) begin : g_iw_chk
        $error("issue_queue: IW must hold a full MIPS instruction");
    end

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    entry_t        h0;
    entry_t        h1;
    logic          dual_ok;
    logic          in_ready;
    logic [1:0]    enq_n;
    logic [1:0]    deq_n;

    logic [IW-1:0] out_inst0_q;
    logic [IW-1:0] out_inst1_q;
    logic [AW-1:0] out_pc0_q;
    logic [AW-1:0] out_pc1_q;
    logic          out_valid0_q;
    logic          out_valid1_q;

    // Deliberately blind to this cycle's dequeue so in_ready has no path from issue logic.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    assign h0 = mem[head_q];
    assign h1 = mem[head_q + PW'(1)];

    pair_hazard u_pair_hazard (
        .h0      (h0.inst[MIPS_IW-1:0]),
        .h1      (h1.inst[MIPS_IW-1:0]),
        .dual_ok (dual_ok)
    );

    always_comb begin
        enq_n = 2'd0;
        if (in_ready && !bus.flush) begin
            case (bus.in_valid)
                2'b01:   enq_n = 2'd1;
                2'b11:   enq_n = 2'd2;
                default: enq_n = 2'd0;
            endcase
        end

        deq_n = 2'd0;
        if (!bus.flush && !bus.stall && (count_q != '0)) begin
            deq_n = ((count_q >= CW'(2)) && dual_ok) ? 2'd2 : 2'd1;
        end
    end

    // Storage carries no reset: validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            mem[tail_q] <= '{inst: bus.in_inst0, pc: bus.in_pc};
        end
        if (enq_n == 2'd2) begin
            mem[tail_q + PW'(1)] <= '{inst: bus.in_inst1, pc: bus.in_pc + AW'(PC_STEP)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(deq_n);
            tail_q  <= tail_q + PW'(enq_n);
            count_q <= count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_inst0_q  <= '0;
            out_inst1_q  <= '0;
            out_pc0_q    <= '0;
            out_pc1_q    <= '0;
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
        end else if (bus.flush) begin
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
        end else if (!bus.stall) begin
            out_valid0_q <= (deq_n != 2'd0);
            out_valid1_q <= (deq_n == 2'd2);
            if (deq_n != 2'd0) begin
                out_inst0_q <= h0.inst;
                out_pc0_q   <= h0.pc;
            end
            if (deq_n == 2'd2) begin
                out_inst1_q <= h1.inst;
                out_pc1_q   <= h1.pc;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.count      = count_q;
    assign bus.out_inst0  = out_inst0_q;
    assign bus.out_inst1  = out_inst1_q;
    assign bus.out_pc0    = out_pc0_q;
    assign bus.out_pc1    = out_pc1_q;
    assign bus.out_valid0 = out_valid0_q;
    assign bus.out_valid1 = out_valid1_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_dual_q;
    logic [31:0] stat_single_q;
    logic [31:0] stat_bubble_q;

    // Counters survive flush so a run's totals include mispredicted stretches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_dual_q   <= '0;
            stat_single_q <= '0;
            stat_bubble_q <= '0;
        end else begin
            if ((deq_n == 2'd2) && (stat_dual_q != '1)) begin
                stat_dual_q <= stat_dual_q + 32'd1;
            end
            if ((deq_n == 2'd1) && (stat_single_q != '1)) begin
                stat_single_q <= stat_single_q + 32'd1;
            end
            if ((deq_n == 2'd0) && !bus.stall && (stat_bubble_q != '1)) begin
                stat_bubble_q <= stat_bubble_q + 32'd1;
            end
        end
    end

    assign bus.stat_dual   = stat_dual_q;
    assign bus.stat_single = stat_single_q;
    assign bus.stat_bubble = stat_bubble_q;
`else
    assign bus.stat_dual   = '0;
    assign bus.stat_single = '0;
    assign bus.stat_bubble = '0;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed scoreboard bench for issue_queue: stimulus pushes expected issues in program order, a negedge monitor pops them.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    issue_queue_if #(.IW(IW), .AW(AW), .CW(CW)) bus ();

    issue_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW), .PC_STEP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   live     = 1'b0;

    logic [31:0] t0 [9];
    logic [31:0] t1 [9];
    bit          td [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] addi(input int rt, input int rs, input int imm);
        return {6'b001000, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, 6'b100000};
    endfunction
    function automatic logic [31:0] jal(input int tgt);
        return {6'b000011, 26'(tgt)};
    endfunction
    function automatic logic [31:0] beq(input int rs, input int rt, input int off);
        return {6'b000100, 5'(rs), 5'(rt), 16'(off)};
    endfunction
    function automatic logic [31:0] jr(input int rs);
        return {6'b000000, 5'(rs), 15'b0, 6'b001000};
    endfunction
    function automatic logic [31:0] sw(input int rt, input int base, input int off);
        return {6'b101011, 5'(base), 5'(rt), 16'(off)};
    endfunction
    // Consecutive PCs always get different destinations and read only $zero, so they pair freely.
    function automatic logic [31:0] seq(input int pc);
        return addi(8 + (pc % 16), 0, pc);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 2'b00;
    endtask

    task automatic send(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input int pc, input bit accept);
        bus.in_valid = v;
        bus.in_inst0 = i0;
        bus.in_inst1 = i1;
        bus.in_pc    = AW'(pc);
        if (accept) begin
            exp_q.push_back('{pc: AW'(pc), inst: i0});
            if (v[1]) exp_q.push_back('{pc: AW'(pc + 1), inst: i1});
        end
    endtask

    task automatic pop_cmp(input string lane, input logic [AW-1:0] pc, input logic [IW-1:0] inst);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: got issue pc 0x%0h, expected no issue", lane, pc);
        end else begin
            e = exp_q.pop_front();
            chk({lane, "_pc"}, 64'(pc), 64'(e.pc));
            chk({lane, "_inst"}, 64'(inst), 64'(e.inst));
        end
    endtask

    // An edge is a real issue opportunity only when reset, stall and flush were all inactive.
    always @(posedge clk) live = rst && !bus.stall && !bus.flush;

    always @(negedge clk) begin
        if (live) begin
            if (bus.out_valid1) chk("lane1_implies_lane0", 64'(bus.out_valid0), 64'd1);
            if (bus.out_valid0) pop_cmp("lane0", bus.out_pc0, bus.out_inst0);
            if (bus.out_valid1) pop_cmp("lane1", bus.out_pc1, bus.out_inst1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        int j;
        t0[0] = add(3, 1, 2);  t1[0] = add(4, 3, 5);   td[0] = 1'b0;
        t0[1] = add(3, 1, 2);  t1[1] = add(4, 5, 3);   td[1] = 1'b0;
        t0[2] = add(7, 1, 2);  t1[2] = add(7, 4, 5);   td[2] = 1'b0;
        t0[3] = add(11, 1, 2); t1[3] = add(12, 1, 2);  td[3] = 1'b1;
        t0[4] = add(6, 1, 2);  t1[4] = jal(16'h40);    td[4] = 1'b0;
        t0[5] = beq(1, 1, 4);  t1[5] = addi(10, 0, 7); td[5] = 1'b0;
        t0[6] = jr(31);        t1[6] = addi(10, 0, 7); td[6] = 1'b0;
        t0[7] = addi(0, 1, 5); t1[7] = add(4, 0, 0);   td[7] = 1'b1;
        t0[8] = sw(5, 6, 0);   t1[8] = add(4, 5, 6);   td[8] = 1'b1;

        bus.in_valid = 2'b00;
        bus.in_inst0 = '0;
        bus.in_inst1 = '0;
        bus.in_pc    = '0;
        bus.flush    = 1'b0;
        bus.stall    = 1'b0;
        rst          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_valid0", 64'(bus.out_valid0), 64'd0);
        chk("rst_valid1", 64'(bus.out_valid1), 64'd0);
        chk("rst_pc0", 64'(bus.out_pc0), 64'd0);
        chk("rst_inst1", 64'(bus.out_inst1), 64'd0);
        chk("rst_stat_dual", 64'(bus.stat_dual), 64'd0);
        chk("rst_stat_bubble", 64'(bus.stat_bubble), 64'd0);
        rst = 1'b1;
        step();

        // Independent addi pairs at full fetch rate.
        for (int k = 0; k < 6; k++) begin
            send(2'b11, addi(8, 0, 2 * k), addi(9, 0, 2 * k + 1), 100 + 2 * k, 1'b1);
            step();
            chk($sformatf("rate%0d_count", k), 64'(bus.count), 64'd2);
            chk($sformatf("rate%0d_dual", k), 64'(bus.out_valid1), 64'(k > 0));
        end
        idle();
        step();
        chk("rate_last_dual", 64'(bus.out_valid1), 64'd1);
        chk("rate_last_pc0", 64'(bus.out_pc0), 64'd110);
        chk("rate_last_count", 64'(bus.count), 64'd0);
`ifdef ISSUE_STATS_EN
        chk("stat_dual_after_rate", 64'(bus.stat_dual), 64'd6);
        chk("stat_single_after_rate", 64'(bus.stat_single), 64'd0);
`endif
        step();
        chk("rate_bubble", 64'(bus.out_valid0), 64'd0);

        // Pairing rules: RAW, WAW, control flow, $zero destinations.
        for (int n = 0; n < 9; n++) begin
            send(2'b11, t0[n], t1[n], 200 + 16 * n, 1'b1);
            step();
            idle();
            step();
            chk($sformatf("pair%0d_dual", n), 64'(bus.out_valid1), 64'(td[n]));
            chk($sformatf("pair%0d_pc0", n), 64'(bus.out_pc0), 64'(200 + 16 * n));
            step();
            chk($sformatf("pair%0d_tail_valid0", n), 64'(bus.out_valid0), 64'(!td[n]));
            if (!td[n]) chk($sformatf("pair%0d_tail_pc0", n), 64'(bus.out_pc0), 64'(201 + 16 * n));
        end

        // Stall: outputs hold, enqueue continues until the full boundary.
        send(2'b11, seq(500), seq(501), 500, 1'b1);
        step();
        send(2'b11, seq(502), seq(503), 502, 1'b1);
        step();
        chk("stall_pre_pc0", 64'(bus.out_pc0), 64'd500);
        chk("stall_pre_dual", 64'(bus.out_valid1), 64'd1);
        bus.stall = 1'b1;
        send(2'b11, seq(504), seq(505), 504, 1'b1);
        step();
        chk("stall1_count", 64'(bus.count), 64'd4);
        chk("stall1_pc0_hold", 64'(bus.out_pc0), 64'd500);
        chk("stall1_valid1_hold", 64'(bus.out_valid1), 64'd1);
        send(2'b01, seq(506), '0, 506, 1'b1);
        step();
        chk("stall2_count", 64'(bus.count), 64'd5);
        send(2'b11, seq(507), seq(508), 507, 1'b1);
        step();
        chk("stall3_count", 64'(bus.count), 64'd7);
        chk("stall3_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall3_pc1_hold", 64'(bus.out_pc1), 64'd501);
        send(2'b11, seq(509), seq(510), 509, 1'b0);
        step();
        chk("stall4_count", 64'(bus.count), 64'd7);
        chk("stall4_pc0_hold", 64'(bus.out_pc0), 64'd500);
        bus.stall = 1'b0;
        step();
        chk("unstall_count", 64'(bus.count), 64'd5);
        chk("unstall_pc0", 64'(bus.out_pc0), 64'd502);
        chk("unstall_in_ready", 64'(bus.in_ready), 64'd1);
        send(2'b11, seq(509), seq(510), 509, 1'b1);
        step();
        chk("resume_count", 64'(bus.count), 64'd5);
        chk("resume_pc0", 64'(bus.out_pc0), 64'd504);
        idle();
        step();
        chk("drain1_pc0", 64'(bus.out_pc0), 64'd506);
        chk("drain1_count", 64'(bus.count), 64'd3);
        step();
        chk("drain2_pc0", 64'(bus.out_pc0), 64'd508);
        step();
        chk("drain3_pc0", 64'(bus.out_pc0), 64'd510);
        chk("drain3_single", 64'(bus.out_valid1), 64'd0);
        chk("drain3_count", 64'(bus.count), 64'd0);
        step();

        // Flush at count 5 beats both stall and a same-cycle enqueue.
        bus.stall = 1'b1;
        send(2'b11, seq(600), seq(601), 600, 1'b1);
        step();
        send(2'b11, seq(602), seq(603), 602, 1'b1);
        step();
        send(2'b01, seq(604), '0, 604, 1'b1);
        step();
        chk("preflush_count", 64'(bus.count), 64'd5);
        bus.flush = 1'b1;
        send(2'b11, seq(605), seq(606), 605, 1'b0);
        exp_q.delete();
        step();
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid0", 64'(bus.out_valid0), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        idle();
        step();
        step();
        chk("postflush_valid0", 64'(bus.out_valid0), 64'd0);
        chk("postflush_count", 64'(bus.count), 64'd0);

        // 40 sequential instructions wrap the pointers several times.
        pc = 1000;
        j  = 0;
        while (pc < 1040) begin
            chk($sformatf("wrap%0d_in_ready", j), 64'(bus.in_ready), 64'd1);
            if ((j % 3 == 2) || (pc == 1039)) begin
                send(2'b01, seq(pc), '0, pc, 1'b1);
                pc += 1;
            end else begin
                send(2'b11, seq(pc), seq(pc + 1), pc, 1'b1);
                pc += 2;
            end
            step();
            j++;
        end
        idle();
        repeat (4) step();
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a stream.
        send(2'b11, seq(2000), seq(2001), 2000, 1'b1);
        step();
        send(2'b11, seq(2002), seq(2003), 2002, 1'b1);
        step();
        chk("prereset_valid0", 64'(bus.out_valid0), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid0", 64'(bus.out_valid0), 64'd0);
        chk("arst_valid1", 64'(bus.out_valid1), 64'd0);
        chk("arst_pc0", 64'(bus.out_pc0), 64'd0);
        chk("arst_inst0", 64'(bus.out_inst0), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_stat_dual", 64'(bus.stat_dual), 64'd0);
        idle();
        step();
        rst = 1'b1;
        step();
        step();
        chk("post_arst_valid0", 64'(bus.out_valid0), 64'd0);
`ifndef ISSUE_STATS_EN
        chk("stat_dual_tied", 64'(bus.stat_dual), 64'd0);
        chk("stat_single_tied", 64'(bus.stat_single), 64'd0);
        chk("stat_bubble_tied", 64'(bus.stat_bubble), 64'd0);
`endif
        chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
